// File: rtl/array_mult_pkg.sv
// rtl/array_mult_pkg.sv - shared constants and row-partition helpers for the pipelined array multiplier
//
// Purpose: latency constant, partial-product row partitioning across the
// pipeline slices, and parameter legality checks.
// Ports: none (package).

package array_mult_pkg;

  // Cycles from an accepted operand beat to out_valid.
  function automatic int lat(input int stages);
    return stages + 2;
  endfunction

  // Rows 1..WIDTH-1 are spread over the slices; row 0 seeds the sum vector.
  // Earlier slices take the extra rows when the split is uneven.
  function automatic int rows_in_slice(input int width, input int stages, input int s);
    int total;
    total = width - 1;
    return total / stages + ((s < (total % stages)) ? 1 : 0);
  endfunction

  function automatic int first_row(input int width, input int stages, input int s);
    int total;
    int rem;
    total = width - 1;
    rem   = total % stages;
    return 1 + s * (total / stages) + ((s < rem) ? s : rem);
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 4) && (width <= 64) && (stages >= 1) && (stages <= width - 1);
  endfunction

endpackage

// File: rtl/array_mult_slice.sv
// rtl/array_mult_slice.sv - one registered slice of the carry-save multiplier array
//
// Purpose: adds partial-product rows FIRST_ROW..FIRST_ROW+NROWS-1 into the
// running sum/carry vectors and registers them with the operand magnitudes
// and the per-beat side-band (valid, sign, zero).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  global pipeline advance
//   in_valid/sign/zero  side-band from the previous stage
//   in_ma, in_mb        operand magnitudes
//   in_sum, in_carry    running carry-save vectors
//   out_*               registered versions for the next stage

module array_mult_slice
  import array_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FIRST_ROW = 1,
  parameter int NROWS     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic [WIDTH-1:0]     in_ma,
  input  logic [WIDTH-1:0]     in_mb,
  input  logic [2*WIDTH-1:0]   in_sum,
  input  logic [2*WIDTH-1:0]   in_carry,
  output logic                 out_valid,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic [WIDTH-1:0]     out_ma,
  output logic [WIDTH-1:0]     out_mb,
  output logic [2*WIDTH-1:0]   out_sum,
  output logic [2*WIDTH-1:0]   out_carry
);

  localparam int PW = 2 * WIDTH;

  wire [PW-1:0] sum_w   [0:NROWS];
  wire [PW-1:0] carry_w [0:NROWS];

  assign sum_w[0]   = in_sum;
  assign carry_w[0] = in_carry;

  for (genvar i = 0; i < NROWS; i++) begin : g_row
    localparam int R = FIRST_ROW + i;
    wire [PW-1:0] pp = in_mb[R] ? ({{WIDTH{1'b0}}, in_ma} << R) : '0;
    wire [PW-2:0] cout_w;

    for (genvar k = 0; k < PW; k++) begin : g_bit
      if (k < PW - 1) begin : g_fa
        full_adder u_fa (
          .a    (sum_w[i][k]),
          .b    (carry_w[i][k]),
          .cin  (pp[k]),
          .sum  (sum_w[i+1][k]),
          .cout (cout_w[k])
        );
      end else begin : g_top
        // Carry out of the top bit falls off the 2*WIDTH result; the product fits.
        assign sum_w[i+1][k] = sum_w[i][k] ^ carry_w[i][k] ^ pp[k];
      end
    end

    assign carry_w[i+1] = {cout_w, 1'b0};
  end

  logic             valid_q, valid_d;
  logic             sign_q,  sign_d;
  logic             zero_q,  zero_d;
  logic [WIDTH-1:0] ma_q,    ma_d;
  logic [WIDTH-1:0] mb_q,    mb_d;
  logic [PW-1:0]    sum_q,   sum_d;
  logic [PW-1:0]    carry_q, carry_d;

  always_comb begin
    valid_d = valid_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (en) begin
      valid_d = in_valid;
      sign_d  = in_sign;
      zero_d  = in_zero;
      ma_d    = in_ma;
      mb_d    = in_mb;
      sum_d   = sum_w[NROWS];
      carry_d = carry_w[NROWS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sign  = sign_q;
  assign out_zero  = zero_q;
  assign out_ma    = ma_q;
  assign out_mb    = mb_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose: carry-save building block for the multiplier array.
// Ports: a, b, cin (addends); sum, cout (results).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_array_multiplier.sv
// rtl/pipelined_array_multiplier.sv - pipelined signed/unsigned array multiplier with valid/ready
//
// Purpose: one product per cycle through front, STAGES array slices, final
// ripple add and output correction stages; latency STAGES+2.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake
//   in_signed           1 = two's-complement operands for this beat
//   a, b                operands
//   out_valid, out_ready result handshake
//   result              2*WIDTH-bit product
//   out_zero            either operand of this beat was zero

module pipelined_array_multiplier
  import array_mult_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 out_zero
);

  localparam int PW = 2 * WIDTH;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_array_multiplier: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  logic en;
  logic out_valid_q, out_valid_d;

  // Whole pipeline moves in lock-step; it stalls only when a result is stuck.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Front stage: magnitudes, sign and zero flag.
  logic             f_valid_q, f_valid_d;
  logic             f_sign_q,  f_sign_d;
  logic             f_zero_q,  f_zero_d;
  logic [WIDTH-1:0] f_ma_q,    f_ma_d;
  logic [WIDTH-1:0] f_mb_q,    f_mb_d;

  always_comb begin
    f_valid_d = f_valid_q;
    f_sign_d  = f_sign_q;
    f_zero_d  = f_zero_q;
    f_ma_d    = f_ma_q;
    f_mb_d    = f_mb_q;
    if (en) begin
      f_valid_d = in_valid;
      // -MIN wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
      f_ma_d    = (in_signed && a[WIDTH-1]) ? -a : a;
      f_mb_d    = (in_signed && b[WIDTH-1]) ? -b : b;
      f_sign_d  = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      f_zero_d  = (a == '0) || (b == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid_q <= 1'b0;
      f_sign_q  <= 1'b0;
      f_zero_q  <= 1'b0;
      f_ma_q    <= '0;
      f_mb_q    <= '0;
    end else begin
      f_valid_q <= f_valid_d;
      f_sign_q  <= f_sign_d;
      f_zero_q  <= f_zero_d;
      f_ma_q    <= f_ma_d;
      f_mb_q    <= f_mb_d;
    end
  end

  // Slice chain; index k feeds slice k, index STAGES is the array output.
  wire             valid_c [0:STAGES];
  wire             sign_c  [0:STAGES];
  wire             zero_c  [0:STAGES];
  wire [WIDTH-1:0] ma_c    [0:STAGES];
  wire [WIDTH-1:0] mb_c    [0:STAGES];
  wire [PW-1:0]    sum_c   [0:STAGES];
  wire [PW-1:0]    carry_c [0:STAGES];

  assign valid_c[0] = f_valid_q;
  assign sign_c[0]  = f_sign_q;
  assign zero_c[0]  = f_zero_q;
  assign ma_c[0]    = f_ma_q;
  assign mb_c[0]    = f_mb_q;
  // Row 0 seeds the sum vector directly; no adders needed for it.
  assign sum_c[0]   = f_mb_q[0] ? {{WIDTH{1'b0}}, f_ma_q} : '0;
  assign carry_c[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    array_mult_slice #(
      .WIDTH     (WIDTH),
      .FIRST_ROW (first_row(WIDTH, STAGES, k)),
      .NROWS     (rows_in_slice(WIDTH, STAGES, k))
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (valid_c[k]),
      .in_sign   (sign_c[k]),
      .in_zero   (zero_c[k]),
      .in_ma     (ma_c[k]),
      .in_mb     (mb_c[k]),
      .in_sum    (sum_c[k]),
      .in_carry  (carry_c[k]),
      .out_valid (valid_c[k+1]),
      .out_sign  (sign_c[k+1]),
      .out_zero  (zero_c[k+1]),
      .out_ma    (ma_c[k+1]),
      .out_mb    (mb_c[k+1]),
      .out_sum   (sum_c[k+1]),
      .out_carry (carry_c[k+1])
    );
  end

  // Magnitudes are no longer needed once every row has been added.
  wire [2*WIDTH-1:0] unused_ops = {ma_c[STAGES], mb_c[STAGES]};

  // Final ripple-carry stage resolves the carry-save pair.
  logic          p_valid_q, p_valid_d;
  logic          p_sign_q,  p_sign_d;
  logic          p_zero_q,  p_zero_d;
  logic [PW-1:0] prod_q,    prod_d;

  always_comb begin
    p_valid_d = p_valid_q;
    p_sign_d  = p_sign_q;
    p_zero_d  = p_zero_q;
    prod_d    = prod_q;
    if (en) begin
      p_valid_d = valid_c[STAGES];
      p_sign_d  = sign_c[STAGES];
      p_zero_d  = zero_c[STAGES];
      prod_d    = sum_c[STAGES] + carry_c[STAGES];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_sign_q  <= 1'b0;
      p_zero_q  <= 1'b0;
      prod_q    <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_sign_q  <= p_sign_d;
      p_zero_q  <= p_zero_d;
      prod_q    <= prod_d;
    end
  end

  // Output stage: sign correction and zero forcing.
  logic [PW-1:0] result_q, result_d;
  logic          out_zero_q, out_zero_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_zero_d  = out_zero_q;
    result_d    = result_q;
    if (en) begin
      out_valid_d = p_valid_q;
      out_zero_d  = p_zero_q;
      if (p_zero_q) begin
        result_d = '0;
      end else if (p_sign_q) begin
        result_d = -prod_q;
      end else begin
        result_d = prod_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_zero_q  <= out_zero_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_zero  = out_zero_q;
  assign result    = result_q;

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// tb/tb_pipelined_array_multiplier.sv - self-checking bench for pipelined_array_multiplier (WIDTH=8, STAGES=3)

module tb_pipelined_array_multiplier;

  localparam int W   = 8;
  localparam int S   = 3;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic          out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipelined_array_multiplier #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic         sgn;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [15:0]  res;
    logic         zero;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural reference: {zero, product[15:0]}.
  function automatic logic [16:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    int xv, yv, p;
    xv = s ? int'($signed(x)) : int'({24'd0, x});
    yv = s ? int'($signed(y)) : int'({24'd0, y});
    p  = xv * yv;
    return {(x == 8'd0) || (y == 8'd0), p[15:0]};
  endfunction

  task automatic send_one(input string name, input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_res, input logic exp_zero);
    int lat_seen;
    lat_seen = -1;
    @(negedge clk);
    in_valid = 1'b1; in_signed = s; a = x; b = y; out_ready = 1'b1;
    #1;
    chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat_seen = k;
        break;
      end
    end
    chk({name, ".latency"}, 64'(lat_seen), 64'(LAT));
    chk({name, ".result"}, 64'(result), 64'(exp_res));
    chk({name, ".out_zero"}, 64'(out_zero), 64'(exp_zero));
  endtask

  task automatic run_stream(input string tag, input int n, input bit rnd, input int hold_start);
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] snap;
    int sent, got;
    bit acc_in;
    sent = 0; got = 0; acc_in = 1'b0; snap = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < n * 20 + 100; cyc++) begin
      @(negedge clk);
      if (!in_valid || acc_in) begin
        if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
          in_valid  = 1'b1;
          in_signed = 1'($urandom_range(0, 1));
          a = 8'($urandom);
          b = 8'($urandom);
          if ($urandom_range(0, 9) == 0) a = 8'd0;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (hold_start >= 0 && cyc >= hold_start && cyc < hold_start + 4) out_ready = 1'b0;
      else if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
      #1;
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk({tag, ".spurious_beat"}, 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk({tag, ".result"}, 64'(result), 64'(e[15:0]));
          chk({tag, ".out_zero"}, 64'(out_zero), 64'(e[16]));
        end
        got++;
      end
      if (acc_in) begin
        q.push_back(model(in_signed, a, b));
        sent++;
      end
      if (hold_start >= 0 && cyc >= hold_start && cyc < hold_start + 4) begin
        chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".hold_out_valid"}, 64'(out_valid), 64'd1);
        if (cyc == hold_start) snap = result;
        else chk({tag, ".hold_result"}, 64'(result), 64'(snap));
      end
      if (got >= n) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, ".beats_out"}, 64'(got), 64'(n));
    chk({tag, ".queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int stale;
    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
    vecs[3]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 8'hFB, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 8'h07, 8'h09, 16'h003F, 1'b0};
    vecs[6]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0};
    vecs[7]  = '{1'b0, 8'h80, 8'h02, 16'h0100, 1'b0};
    vecs[8]  = '{1'b1, 8'h05, 8'hFD, 16'hFFF1, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.out_zero", 64'(out_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      send_one($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero);
      @(negedge clk);
    end

    // Back-pressure: 8 mixed-mode beats, out_ready low for 4 cycles mid-stream.
    run_stream("bp", 8, 1'b0, 7);

    // Reset with 3 beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; a = 8'(i + 1); b = 8'd3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid.pre_out_valid", 64'(out_valid), 64'd1);
    chk("rst_mid.pre_result", 64'(result), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid.result", 64'(result), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("rst_mid.stale_beats", 64'(stale), 64'd0);
    send_one("rst_mid.7x9", 1'b0, 8'd7, 8'd9, 16'd63, 1'b0);
    @(negedge clk);

    // Soak with random in_valid / out_ready, both modes.
    run_stream("soak", 2000, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
